// File: rtl/mac_table_engine.sv
// MAC learning/forwarding table: edge-qualified learn/lookup/aging commands from the
// access arbiter, register-based entry storage, 3-edge lookup pipeline with write-first bypass.
module mac_table_engine #(
  parameter int pPORT_WIDTH      = 4,
  parameter int pMAC_MEM_DEPTH_W = 8,
  parameter int pDATA_WIDTH      = 8,
  parameter int pAGE_W           = 4
) (
  input  logic                           iclk,
  input  logic                           irst,
  input  logic                           i_write_en,
  input  logic                           i_read_en,
  input  logic                           i_decrement,
  input  logic [$clog2(pPORT_WIDTH)-1:0] i_port_num,
  input  logic [pMAC_MEM_DEPTH_W-1:0]    i_MAC_SA,
  input  logic [pMAC_MEM_DEPTH_W-1:0]    i_MAC_DA,
  input  logic [pDATA_WIDTH-1:0]         i_check_byte_SA,
  input  logic [pDATA_WIDTH-1:0]         i_check_byte_DA,
  output logic                           o_fwd_valid,
  output logic [$clog2(pPORT_WIDTH)-1:0] o_fwd_src_port,
  output logic [pPORT_WIDTH-1:0]         o_fwd_mask,
  output logic                           o_fwd_hit,
  output logic [pMAC_MEM_DEPTH_W:0]      o_table_count
);
  localparam int PW     = $clog2(pPORT_WIDTH);
  localparam int DEPTH  = 2**pMAC_MEM_DEPTH_W;
  localparam int CW     = pMAC_MEM_DEPTH_W + 1;
  localparam int STAGES = 2;

  logic [DEPTH-1:0]       valid_q;
  logic [pDATA_WIDTH-1:0] chk_q  [DEPTH];
  logic [PW-1:0]          port_q [DEPTH];
  logic [pAGE_W-1:0]      age_q  [DEPTH];

  logic                        we_d, re_d;
  logic [PW-1:0]               port_d;
  logic [pMAC_MEM_DEPTH_W-1:0] age_ptr;
  logic                        learn_acc, look_acc, age_acc, expire;
  logic [pAGE_W-1:0]           age_val;

  // A held level only re-arms when the arbiter hands the slot to another port.
  assign learn_acc = i_write_en & (~we_d | (i_port_num != port_d));
  assign look_acc  = i_read_en  & (~re_d | (i_port_num != port_d));
  assign age_acc   = i_decrement & ~learn_acc & ~look_acc;
  assign age_val   = age_q[age_ptr];
  assign expire    = age_acc & valid_q[age_ptr] & (age_val <= pAGE_W'(1));

  always_ff @(posedge iclk) begin
    if (irst) begin
      we_d    <= 1'b0;
      re_d    <= 1'b0;
      port_d  <= '0;
      age_ptr <= '0;
    end else begin
      we_d   <= i_write_en;
      re_d   <= i_read_en;
      port_d <= i_port_num;
      if (age_acc) age_ptr <= age_ptr + 1'b1;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst)           valid_q <= '0;
    else if (learn_acc) valid_q[i_MAC_SA] <= 1'b1;
    else if (expire)    valid_q[age_ptr] <= 1'b0;
  end

  always_ff @(posedge iclk) begin
    if (learn_acc) begin
      chk_q[i_MAC_SA]  <= i_check_byte_SA;
      port_q[i_MAC_SA] <= i_port_num;
      age_q[i_MAC_SA]  <= '1;
    end else if (age_acc && valid_q[age_ptr]) begin
      age_q[age_ptr] <= expire ? '0 : age_val - pAGE_W'(1);
    end
  end

  always_ff @(posedge iclk) begin
    if (irst)                                     o_table_count <= '0;
    else if (learn_acc && !valid_q[i_MAC_SA])     o_table_count <= o_table_count + CW'(1);
    else if (expire)                              o_table_count <= o_table_count - CW'(1);
  end

  // Write-first: a same-cycle learn to the looked-up index overrides the stored entry.
  logic                   byp, rd_vld;
  logic [pDATA_WIDTH-1:0] rd_chk;
  logic [PW-1:0]          rd_port;
  assign byp     = learn_acc & (i_MAC_SA == i_MAC_DA);
  assign rd_vld  = byp | valid_q[i_MAC_DA];
  assign rd_chk  = byp ? i_check_byte_SA : chk_q[i_MAC_DA];
  assign rd_port = byp ? i_port_num      : port_q[i_MAC_DA];

  logic [STAGES:0]        vld_pipe;
  logic [PW-1:0]          s1_src, s1_ent_port, s2_src;
  logic [pDATA_WIDTH-1:0] s1_chk, s1_ent_chk;
  logic                   s1_ent_vld, s2_hit, hit;
  logic [pPORT_WIDTH-1:0] s2_mask, mask, src_oh, ent_oh;

  assign src_oh = pPORT_WIDTH'(1) << s1_src;
  assign ent_oh = pPORT_WIDTH'(1) << s1_ent_port;
  assign hit    = s1_ent_vld & (s1_ent_chk == s1_chk);
  assign mask   = hit ? ((s1_ent_port == s1_src) ? '0 : ent_oh) : ~src_oh;

  always_ff @(posedge iclk) begin
    if (irst) begin
      vld_pipe       <= '0;
      s1_src         <= '0;
      s1_chk         <= '0;
      s1_ent_vld     <= 1'b0;
      s1_ent_chk     <= '0;
      s1_ent_port    <= '0;
      s2_src         <= '0;
      s2_hit         <= 1'b0;
      s2_mask        <= '0;
      o_fwd_src_port <= '0;
      o_fwd_hit      <= 1'b0;
      o_fwd_mask     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], look_acc};
      if (look_acc) begin
        s1_src      <= i_port_num;
        s1_chk      <= i_check_byte_DA;
        s1_ent_vld  <= rd_vld;
        s1_ent_chk  <= rd_chk;
        s1_ent_port <= rd_port;
      end
      if (vld_pipe[0]) begin
        s2_src  <= s1_src;
        s2_hit  <= hit;
        s2_mask <= mask;
      end
      if (vld_pipe[1]) begin
        o_fwd_src_port <= s2_src;
        o_fwd_hit      <= s2_hit;
        o_fwd_mask     <= s2_mask;
      end
    end
  end

  assign o_fwd_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_mac_table_engine.sv
// Bench for mac_table_engine: table of lookup scenarios, hand sequences for aging,
// level-held learn and reset-mid-lookup, then random traffic against a table model.
module tb_mac_table_engine;
  localparam int DEPTH = 256;

  logic       iclk = 1'b0;
  logic       irst, we, re, dec;
  logic [1:0] port;
  logic [7:0] sa, da, csa, cda;
  logic       o_fwd_valid, o_fwd_hit;
  logic [1:0] o_fwd_src_port;
  logic [3:0] o_fwd_mask;
  logic [8:0] o_table_count;

  mac_table_engine dut (
    .iclk(iclk), .irst(irst), .i_write_en(we), .i_read_en(re), .i_decrement(dec),
    .i_port_num(port), .i_MAC_SA(sa), .i_MAC_DA(da),
    .i_check_byte_SA(csa), .i_check_byte_DA(cda),
    .o_fwd_valid(o_fwd_valid), .o_fwd_src_port(o_fwd_src_port), .o_fwd_mask(o_fwd_mask),
    .o_fwd_hit(o_fwd_hit), .o_table_count(o_table_count)
  );

  always #5 iclk = ~iclk;

  // Reference table: plain arrays, a pending-result queue tagged with the due cycle.
  typedef struct { int due; logic [1:0] src; bit hit; logic [3:0] mask; } res_t;
  bit         m_v   [DEPTH];
  logic [7:0] m_c   [DEPTH];
  logic [1:0] m_p   [DEPTH];
  int         m_age [DEPTH];
  int         m_ptr, m_cnt, cyc;
  bit         m_pwe, m_pre;
  logic [1:0] m_pport;
  res_t       pend[$];

  int         n_cmp = 0, n_bad = 0;
  bit         got;
  bit         got_hit;
  logic [3:0] got_mask;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit la, lk;
    res_t r;
    cyc++;
    if (irst) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
      m_ptr = 0; m_cnt = 0; m_pwe = 0; m_pre = 0; m_pport = 0;
      pend.delete();
      return;
    end
    la = we && (!m_pwe || port != m_pport);
    lk = re && (!m_pre || port != m_pport);
    if (la) begin
      if (!m_v[sa]) m_cnt++;
      m_v[sa] = 1; m_c[sa] = csa; m_p[sa] = port; m_age[sa] = 15;
    end
    if (lk) begin
      r.due = cyc + 2;
      r.src = port;
      r.hit = m_v[da] && (m_c[da] == cda);
      if (r.hit) r.mask = (m_p[da] == port) ? 4'b0000 : (4'b0001 << m_p[da]);
      else       r.mask = 4'b1111 & ~(4'b0001 << port);
      pend.push_back(r);
    end
    if (dec && !la && !lk) begin
      if (m_v[m_ptr]) begin
        m_age[m_ptr]--;
        if (m_age[m_ptr] == 0) begin m_v[m_ptr] = 0; m_cnt--; end
      end
      m_ptr = (m_ptr + 1) % DEPTH;
    end
    m_pwe = we; m_pre = re; m_pport = port;
  endtask

  task automatic check();
    res_t r;
    cmp("count", 32'(o_table_count), 32'(m_cnt));
    if (o_fwd_valid === 1'b1) begin got = 1; got_hit = o_fwd_hit; got_mask = o_fwd_mask; end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      cmp("fwd_valid", 32'(o_fwd_valid), 32'd1);
      cmp("fwd_src",   32'(o_fwd_src_port), 32'(r.src));
      cmp("fwd_hit",   32'(o_fwd_hit), 32'(r.hit));
      cmp("fwd_mask",  32'(o_fwd_mask), 32'(r.mask));
    end else begin
      cmp("fwd_idle", 32'(o_fwd_valid), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    model_edge();
    @(negedge iclk);
    check();
  endtask

  task automatic do_reset();
    irst = 1; tick(); irst = 0;
  endtask

  typedef struct {
    bit learn; logic [7:0] sa; logic [7:0] sachk; logic [1:0] saport;
    logic [7:0] da; logic [7:0] dachk; logic [1:0] src;
    bit exp_hit; logic [3:0] exp_mask; int exp_cnt;
  } vec_t;

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    if (v.learn) begin
      we = 1; port = v.saport; sa = v.sa; csa = v.sachk; tick();
      we = 0; tick();
    end
    re = 1; port = v.src; da = v.da; cda = v.dachk; got = 0; tick();
    re = 0;
    lat = 0;
    while (!got && lat < 6) begin tick(); lat++; end
    cmp({nm, "_seen"}, 32'(got), 32'd1);
    if (got) begin
      cmp({nm, "_lat"},  32'(lat), 32'd2);
      cmp({nm, "_hit"},  32'(got_hit), 32'(v.exp_hit));
      cmp({nm, "_mask"}, 32'(got_mask), 32'(v.exp_mask));
    end
    cmp({nm, "_cnt"}, 32'(o_table_count), 32'(v.exp_cnt));
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{0, 8'd0, 8'h00, 2'd0, 8'd5,  8'h00, 2'd2, 0, 4'b1011, 0};
    vecs[1] = '{1, 8'd5, 8'hA3, 2'd1, 8'd5,  8'hA3, 2'd0, 1, 4'b0010, 1};
    vecs[2] = '{0, 8'd0, 8'h00, 2'd0, 8'd5,  8'hA4, 2'd0, 0, 4'b1110, 1};
    vecs[3] = '{0, 8'd0, 8'h00, 2'd0, 8'd5,  8'hA3, 2'd1, 1, 4'b0000, 1};
    vecs[4] = '{1, 8'd5, 8'hA3, 2'd3, 8'd5,  8'hA3, 2'd0, 1, 4'b1000, 1};
    vecs[5] = '{1, 8'd9, 8'h11, 2'd2, 8'd9,  8'h11, 2'd2, 1, 4'b0000, 2};
    vecs[6] = '{0, 8'd0, 8'h00, 2'd0, 8'd10, 8'h00, 2'd3, 0, 4'b0111, 2};

    irst = 1; we = 0; re = 0; dec = 0; port = 0; sa = 0; da = 0; csa = 0; cda = 0;
    cyc = 0; m_ptr = 0; m_cnt = 0;
    tick(); tick();
    cmp("rst_count", 32'(o_table_count), 32'd0);
    cmp("rst_valid", 32'(o_fwd_valid), 32'd0);
    irst = 0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Aging: entry 7 survives 14 full sweeps and expires on the 15th.
    do_reset();
    we = 1; port = 2; sa = 7; csa = 8'h55; tick();
    we = 0; dec = 1;
    repeat (14 * DEPTH) tick();
    cmp("age_alive", 32'(o_table_count), 32'd1);
    repeat (DEPTH) tick();
    cmp("age_expired", 32'(o_table_count), 32'd0);
    dec = 0;
    run_vec('{0, 8'd0, 8'h00, 2'd0, 8'd7, 8'h55, 2'd0, 0, 4'b1110, 0}, "aged");

    // Level-held learn: one accept per level, re-armed by a port change.
    do_reset();
    we = 1; port = 1; sa = 20; csa = 8'h01;
    repeat (6) tick();
    cmp("held_once", 32'(o_table_count), 32'd1);
    port = 2; sa = 21; tick();
    cmp("port_change", 32'(o_table_count), 32'd2);
    we = 0; tick();

    // Reset one cycle after a lookup accept drops the result and the table.
    do_reset();
    we = 1; port = 3; sa = 30; csa = 8'h77; tick();
    we = 0; tick();
    re = 1; port = 0; da = 30; cda = 8'h77; got = 0; tick();
    re = 0; irst = 1; tick(); irst = 0;
    repeat (5) tick();
    cmp("rst_drop_fwd", 32'(got), 32'd0);
    cmp("rst_drop_cnt", 32'(o_table_count), 32'd0);
    run_vec('{0, 8'd0, 8'h00, 2'd0, 8'd30, 8'h77, 2'd0, 0, 4'b1110, 0}, "rst_gone");

    // Random traffic on a small index set so hits, moves and filters are common.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      we   = ($urandom % 4) == 0;
      re   = ($urandom % 3) == 0;
      dec  = $urandom % 2;
      port = 2'($urandom % 4);
      sa   = 8'($urandom % 8);
      da   = 8'($urandom % 8);
      csa  = 8'($urandom % 2);
      cda  = 8'($urandom % 2);
      irst = ($urandom % 400) == 0;
      tick();
    end
    irst = 0; we = 0; re = 0; dec = 0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
